// File: rtl/cache_pkg.sv
// Shared definitions for the cache data store: width derivations and fill-engine states.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  function automatic int calc_set_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int calc_way_w(input int num_ways);
    return $clog2(num_ways);
  endfunction

  function automatic int calc_off_w(input int words_per_block);
    return $clog2(words_per_block);
  endfunction

  function automatic int calc_be_w(input int word_w);
    return word_w / 8;
  endfunction

  function automatic int calc_block_w(input int words_per_block, input int word_w);
    return words_per_block * word_w;
  endfunction

endpackage

// File: rtl/cache_data_way.sv
// One way of the data store: NUM_SETS blocks, byte-enabled word write, combinational set read.
module cache_data_way import cache_pkg::*; #(
  parameter  int NUM_SETS        = 32,
  parameter  int WORDS_PER_BLOCK = 8,
  parameter  int WORD_W          = 32,
  localparam int SET_W           = calc_set_w(NUM_SETS),
  localparam int OFF_W           = calc_off_w(WORDS_PER_BLOCK),
  localparam int BE_W            = calc_be_w(WORD_W),
  localparam int BLOCK_W         = calc_block_w(WORDS_PER_BLOCK, WORD_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [SET_W-1:0]   wr_set,
  input  logic [OFF_W-1:0]   wr_word,
  input  logic [BE_W-1:0]    wr_be,
  input  logic [WORD_W-1:0]  wr_data,
  input  logic [SET_W-1:0]   rd_set,
  output logic [BLOCK_W-1:0] rd_block
);

  logic [BLOCK_W-1:0] mem_r [NUM_SETS];

  // Storage: cleared on reset, otherwise only enabled bytes of the addressed word change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        mem_r[s] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) begin
          mem_r[wr_set][int'(wr_word)*WORD_W + b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  assign rd_block = mem_r[rd_set];

endmodule

// File: rtl/cache_data_array.sv
// Set-associative data array: all-ways registered read, store-hit word write, line-fill engine.
module cache_data_array import cache_pkg::*; #(
  parameter  int NUM_WAYS        = 8,
  parameter  int NUM_SETS        = 32,
  parameter  int WORDS_PER_BLOCK = 8,
  parameter  int WORD_W          = 32,
  localparam int BLOCK_W         = calc_block_w(WORDS_PER_BLOCK, WORD_W),
  localparam int WAY_W           = calc_way_w(NUM_WAYS),
  localparam int SET_W           = calc_set_w(NUM_SETS),
  localparam int OFF_W           = calc_off_w(WORDS_PER_BLOCK),
  localparam int BE_W            = calc_be_w(WORD_W)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rd_en,
  input  logic [SET_W-1:0]            rd_set,
  output logic [NUM_WAYS*BLOCK_W-1:0] rd_data,
  output logic                        rd_valid,
  input  logic                        wr_en,
  input  logic [WAY_W-1:0]            wr_way,
  input  logic [SET_W-1:0]            wr_set,
  input  logic [OFF_W-1:0]            wr_word,
  input  logic [BE_W-1:0]             wr_be,
  input  logic [WORD_W-1:0]           wr_data,
  output logic                        wr_ready,
  input  logic                        fill_start,
  input  logic [WAY_W-1:0]            fill_way,
  input  logic [SET_W-1:0]            fill_set,
  input  logic                        fill_valid,
  input  logic [WORD_W-1:0]           fill_data,
  output logic                        fill_ready,
  output logic                        fill_busy,
  output logic                        fill_done
);

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_BLOCK - 1);

  fill_state_t              state_r, state_nx_s;
  logic [OFF_W-1:0]         cnt_r, cnt_nx_s;
  logic [WAY_W-1:0]         fway_r, fway_nx_s;
  logic [SET_W-1:0]         fset_r, fset_nx_s;
  logic                     beat_s, store_s;
  logic [SET_W-1:0]         w_set_s;
  logic [OFF_W-1:0]         w_word_s;
  logic [BE_W-1:0]          w_be_s;
  logic [WORD_W-1:0]        w_data_s;
  logic [NUM_WAYS*BLOCK_W-1:0] rd_all_s;

  assign fill_ready = (state_r == FILL);
  assign fill_busy  = (state_r != IDLE);
  assign fill_done  = (state_r == DONE);
  assign wr_ready   = ~fill_busy;
  assign beat_s     = fill_ready & fill_valid;
  assign store_s    = wr_en & wr_ready;

  // Fill FSM next state, beat counter and latched refill target.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    fway_nx_s  = fway_r;
    fset_nx_s  = fset_r;
    case (state_r)
      IDLE: begin
        if (fill_start) begin
          state_nx_s = FILL;
          cnt_nx_s   = '0;
          fway_nx_s  = fill_way;
          fset_nx_s  = fill_set;
        end else begin
          state_nx_s = IDLE;
        end
      end
      FILL: begin
        if (fill_valid && (cnt_r == LAST_BEAT)) begin
          state_nx_s = DONE;
          cnt_nx_s   = '0;
        end else if (fill_valid) begin
          cnt_nx_s   = cnt_r + OFF_W'(1);
        end else begin
          state_nx_s = FILL;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Fill FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      fway_r  <= '0;
      fset_r  <= '0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      fway_r  <= fway_nx_s;
      fset_r  <= fset_nx_s;
    end
  end

  // Shared write port; a fill beat and a store write can never coincide since wr_ready is ~fill_busy.
  always_comb begin
    if (beat_s) begin
      w_set_s  = fset_r;
      w_word_s = cnt_r;
      w_be_s   = '1;
      w_data_s = fill_data;
    end else begin
      w_set_s  = wr_set;
      w_word_s = wr_word;
      w_be_s   = wr_be;
      w_data_s = wr_data;
    end
  end

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    logic way_we_s;
    assign way_we_s = (beat_s  && (fway_r == WAY_W'(w))) ||
                      (store_s && (wr_way == WAY_W'(w)));

    cache_data_way #(
      .NUM_SETS        (NUM_SETS),
      .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
      .WORD_W          (WORD_W)
    ) u_way (
      .clk      (clk),
      .reset    (reset),
      .we       (way_we_s),
      .wr_set   (w_set_s),
      .wr_word  (w_word_s),
      .wr_be    (w_be_s),
      .wr_data  (w_data_s),
      .rd_set   (rd_set),
      .rd_block (rd_all_s[w*BLOCK_W +: BLOCK_W])
    );
  end

  // Read register: samples pre-write contents, so same-edge writes are not seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_all_s;
      end else begin
        rd_data <= rd_data;
      end
    end
  end

endmodule

// File: doc/cache_data_array.md
# cache_data_array

Parametrised data store for the set-associative cache, generalising the current 8-way data array into configurable ways, sets, words-per-block and word width. It adds a registered all-ways read port, a byte-masked single-word write port for store hits, and a built-in line-fill engine that writes a refill block beat by beat from the memory side under a valid/ready handshake. It sits beside the tag array. The cache controller drives reads and store writes. The refill path drives fill beats.

## Interface
- NUM_WAYS, 8, associativity; power of two ≥ 2
- NUM_SETS, 32, sets per way; power of two ≥ 2
- WORDS_PER_BLOCK, 8, words per line; power of two ≥ 2
- WORD_W, 32, word width in bits; multiple of 8
- Derived (not overridable): BLOCK_W = WORDS_PER_BLOCK*WORD_W, WAY_W = log2(NUM_WAYS), SET_W = log2(NUM_SETS), OFF_W = log2(WORDS_PER_BLOCK), BE_W = WORD_W/8

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- rd_en  in  1  read request
- rd_set  in  SET_W  set to read
- rd_data  out  NUM_WAYS*BLOCK_W  block for each way; way w at [w*BLOCK_W +: BLOCK_W]
- rd_valid  out  1  rd_data is updated this cycle
- wr_en  in  1  store-hit word write
- wr_way  in  WAY_W  target way
- wr_set  in  SET_W  target set
- wr_word  in  OFF_W  word offset in the block
- wr_be  in  BE_W  byte enables; bit b covers bits [8b+7:8b]
- wr_data  in  WORD_W  store data
- wr_ready  out  1  store write accepted when wr_en & wr_ready
- fill_start  in  1  begin line refill
- fill_way  in  WAY_W  refill way, sampled with fill_start
- fill_set  in  SET_W  refill set, sampled with fill_start
- fill_valid  in  1  refill beat valid
- fill_data  in  WORD_W  refill beat, word 0 first
- fill_ready  out  1  beat accepted when fill_valid & fill_ready
- fill_busy  out  1  fill engine not idle
- fill_done  out  1  one-cycle pulse after the last beat is written

## Operation
- Storage: NUM_WAYS × NUM_SETS × BLOCK_W flops. Reset clears all storage to 0.
- Read: rd_en high → rd_data is loaded with all ways of rd_set at the next edge, and rd_valid=1 that cycle. When rd_en is low, rd_data holds its value and rd_valid=0.
- Read-during-write: a read returns contents from before any write on the same edge, whether a store write or a fill beat.
- Store write: on wr_en & wr_ready, only the bytes of word wr_word in (wr_way, wr_set) with wr_be=1 are updated. wr_be=0 is a legal no-op.
- wr_ready = ~fill_busy. Store writes offered during a fill are not taken; the controller holds them.
- Fill FSM states: IDLE, FILL, DONE.
  - IDLE: fill_start → latch way and set, clear beat counter, go to FILL.
  - FILL: fill_ready=1. Each accepted beat writes the full word at the counter position, then the counter increments.
    - Beat WORDS_PER_BLOCK-1 accepted → DONE.
    - fill_valid low stalls with no write.
  - DONE: fill_done=1 for one cycle, then IDLE.
- fill_start outside IDLE is ignored; fill_way and fill_set are not resampled.
- Beat counter is OFF_W bits and never wraps inside a fill.

## Timing
- Reset values: rd_data=0, rd_valid=0, fill_ready=0, fill_busy=0, fill_done=0, wr_ready=1, FSM=IDLE, counter=0.
- Reset asserted mid-fill aborts the fill: FSM returns to IDLE and storage is cleared. A partially filled line is never visible after reset.
- Read latency: 1 cycle. Write latency: data is visible to a read issued on the following cycle.
- fill_start at edge t: fill_busy=1 and fill_ready=1 from t+1.
- Back-to-back beats fill the line in WORDS_PER_BLOCK cycles. fill_done is asserted in the cycle after the last beat. fill_busy drops, and wr_ready rises, one cycle after that.
- wr_ready and fill_ready are combinational from FSM state only. No combinational path runs from any input to any output.

## Structure
- Shared package cache_pkg holds:
  - the width-derivation functions (clog2-based SET_W, WAY_W, OFF_W, BE_W, BLOCK_W)
  - the fill-state enum fill_state_t {IDLE, FILL, DONE}
- One sub-module, cache_data_way, is instantiated NUM_WAYS times. It holds NUM_SETS blocks with an async-reset clear, a word/byte-enable write port and a combinational set-indexed read.
- The top level contains the fill FSM, write muxing (the fill path and the store path are mutually exclusive by construction) and the rd_data register.

## Test plan
- Reset then read sets 0 and 31 → rd_valid=1 one cycle later, rd_data all zeros.
- Store write: way 3, set 5, word 2, wr_be=4'b0101, data 0xAABBCCDD onto a zeroed line → read set 5 returns way 3 word 2 = 0x00BB00DD; all other words and ways are 0.
- Fill way 7, set 31 with beats 0x100..0x107 with no stall → fill_done exactly 8 cycles after the first beat cycle; read returns words 0..7 = 0x100..0x107; wr_ready low throughout fill_busy.
- Same fill with fill_valid toggling every other cycle → identical final contents; no write on cycles with fill_valid low; a second fill_start mid-fill is ignored.
- Read set 31 on the same edge as the final fill beat → returns the old word 7; a read on the next cycle returns 0x107.
- Assert reset after 4 of 8 fill beats → FSM goes to IDLE, fill_busy=0, and set 31 reads as all zeros after release.
